stripe_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the byte striping datapath between two byte-stream requesters. It grants one requester at a time in bounded bursts and forwards its bytes as a registered valid/data stream into the striper's `valid_in`/`data_in`. It pads odd-length bursts with one filler byte, so every burst starts on lane 0 of the two-lane striper.

---
 rtl/stripe_arbiter.sv | 134 +++++++++++++
 tb/tb_stripe_arbiter.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stripe_arbiter.sv
// stripe_arbiter
//   Round-robin arbiter/sequencer sharing the two-lane byte striper between
//   two byte-stream requesters. Grants one requester at a time for bursts of
//   up to BURST_MAX bytes. Odd-length bursts are followed by one PAD_BYTE, so
//   every burst begins on striper lane 0.
//
// Ports
//   clk_2f                 single rising-edge clock
//   reset                  asynchronous active-high reset
//   req0_valid/data/last   requester 0 byte stream (in)
//   req0_ready             requester 0 byte accepted this cycle (out)
//   req1_valid/data/last   requester 1 byte stream (in)
//   req1_ready             requester 1 byte accepted this cycle (out)
//   valid_out, data_out    registered stream into the striper valid_in/data_in
//   owner                  requester that sourced the current output byte
//   busy                   state machine is not IDLE
//
// state | meaning
// IDLE  | no grant, arbitrating on incoming valids
// GNT0  | requester 0 owns the striper
// GNT1  | requester 1 owns the striper
// PAD   | one-cycle filler after an odd-length burst
module stripe_arbiter #(
  parameter int          BURST_MAX = 4,
  parameter logic [7:0]  PAD_BYTE  = 8'hBC
) (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       valid_out,
  output logic [7:0] data_out,
  output logic       owner,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, PAD} state_t;

  localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);

  state_t     state;
  state_t     arb_next;
  logic       last_owner;
  logic [3:0] cnt;
  logic       pad_owner;

  logic       cur;
  logic       cur_valid;
  logic       cur_last;
  logic [7:0] cur_data;
  logic       other_valid;
  logic       xfer;
  logic       burst_end;

  // Ties go to the requester that did not own the previous burst.
  function automatic state_t arb(input logic a0, input logic a1, input logic lo);
    if (a0 && a1) return lo ? GNT0 : GNT1;
    else if (a0)  return GNT0;
    else if (a1)  return GNT1;
    else          return IDLE;
  endfunction

  always_comb begin
    cur         = (state == GNT1);
    cur_valid   = cur ? req1_valid : req0_valid;
    cur_last    = cur ? req1_last  : req0_last;
    cur_data    = cur ? req1_data  : req0_data;
    other_valid = cur ? req0_valid : req1_valid;
    xfer        = ((state == GNT0) || (state == GNT1)) && cur_valid;
    burst_end   = xfer && (cur_last || (cnt == CNT_LAST));
    arb_next    = arb(req0_valid, req1_valid, last_owner);
  end

  assign req0_ready = (state == GNT0);
  assign req1_ready = (state == GNT1);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      cnt        <= 4'd0;
      pad_owner  <= 1'b0;
      valid_out  <= 1'b0;
      data_out   <= 8'h00;
      owner      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        IDLE, PAD: begin
          if (state == PAD) begin
            valid_out <= 1'b1;
            data_out  <= PAD_BYTE;
            owner     <= pad_owner;
          end
          state <= arb_next;
          if (arb_next != IDLE) begin
            last_owner <= (arb_next == GNT1);
            cnt        <= 4'd0;
          end
        end
        GNT0, GNT1: begin
          if (xfer) begin
            valid_out <= 1'b1;
            data_out  <= cur_data;
            owner     <= cur;
            cnt       <= cnt + 4'd1;
          end
          if (burst_end) begin
            // cnt is the index of this byte, so even cnt means odd length.
            if (!cnt[0]) begin
              state     <= PAD;
              pad_owner <= cur;
            end else if (other_valid) begin
              state      <= cur ? GNT0 : GNT1;
              last_owner <= ~cur;
              cnt        <= 4'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stripe_arbiter.sv
// Testbench for stripe_arbiter: directed scenarios plus a scoreboard that
// predicts the forwarded byte stream (including pad bytes) from each accepted
// requester byte and checks lane-0 alignment of every burst start.
module tb_stripe_arbiter;

  localparam int         BURST_MAX = 4;
  localparam logic [7:0] PAD_BYTE  = 8'hBC;

  typedef struct packed {
    logic       first;
    logic       own;
    logic [7:0] data;
  } exp_t;

  logic       clk_2f = 1'b0;
  logic       reset  = 1'b1;
  logic [1:0] r_valid = 2'b00;
  logic [1:0] r_last  = 2'b00;
  logic [7:0] r_data0 = 8'h00;
  logic [7:0] r_data1 = 8'h00;
  wire  [1:0] r_ready;
  wire        valid_out;
  wire  [7:0] data_out;
  wire        owner;
  wire        busy;

  int checks = 0;
  int errors = 0;

  exp_t       sb_q[$];
  logic [8:0] src0_q[$];
  logic [8:0] src1_q[$];
  int         sb_cnt0 = 0;
  int         sb_cnt1 = 0;
  int         out_count = 0;
  logic       stall0 = 1'b0;
  logic       stall1 = 1'b0;

  stripe_arbiter #(.BURST_MAX(BURST_MAX), .PAD_BYTE(PAD_BYTE)) dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .req0_valid (r_valid[0]),
    .req0_data  (r_data0),
    .req0_last  (r_last[0]),
    .req0_ready (r_ready[0]),
    .req1_valid (r_valid[1]),
    .req1_data  (r_data1),
    .req1_last  (r_last[1]),
    .req1_ready (r_ready[1]),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .owner      (owner),
    .busy       (busy)
  );

  always #5 clk_2f = ~clk_2f;

  // Requester sources: present the queue head, pop it after an accepted cycle.
  task automatic src0_proc();
    logic fire;
    forever begin
      @(negedge clk_2f);
      fire = r_valid[0] & r_ready[0];
      @(posedge clk_2f);
      #1;
      if (fire && src0_q.size() > 0) void'(src0_q.pop_front());
      if (src0_q.size() > 0 && !stall0) begin
        r_valid[0] = 1'b1;
        r_last[0]  = src0_q[0][8];
        r_data0    = src0_q[0][7:0];
      end else begin
        r_valid[0] = 1'b0;
      end
    end
  endtask

  task automatic src1_proc();
    logic fire;
    forever begin
      @(negedge clk_2f);
      fire = r_valid[1] & r_ready[1];
      @(posedge clk_2f);
      #1;
      if (fire && src1_q.size() > 0) void'(src1_q.pop_front());
      if (src1_q.size() > 0 && !stall1) begin
        r_valid[1] = 1'b1;
        r_last[1]  = src1_q[0][8];
        r_data1    = src1_q[0][7:0];
      end else begin
        r_valid[1] = 1'b0;
      end
    end
  endtask

  // Expected output for one accepted byte, plus a pad if it closes an odd burst.
  task automatic model_xfer(input logic x, input logic [7:0] d, input logic l);
    int   c;
    exp_t e;
    c = x ? sb_cnt1 : sb_cnt0;
    e.first = (c == 0);
    e.own   = x;
    e.data  = d;
    sb_q.push_back(e);
    c++;
    if (l || c == BURST_MAX) begin
      if (c % 2 == 1) begin
        e.first = 1'b0;
        e.own   = x;
        e.data  = PAD_BYTE;
        sb_q.push_back(e);
      end
      c = 0;
    end
    if (x) sb_cnt1 = c;
    else   sb_cnt0 = c;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_2f);
      if (reset) begin
        sb_q.delete();
        sb_cnt0   = 0;
        sb_cnt1   = 0;
        out_count = 0;
      end else begin
        if (valid_out) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra got owner=%0d data=%h expected no output", owner, data_out);
          end else begin
            e = sb_q.pop_front();
            if ({owner, data_out} !== {e.own, e.data}) begin
              errors++;
              $display("FAIL sb_data got owner=%0d data=%h expected owner=%0d data=%h",
                       owner, data_out, e.own, e.data);
            end
            if (e.first) begin
              checks++;
              if (out_count % 2 != 0) begin
                errors++;
                $display("FAIL lane0 burst start at output position %0d expected even", out_count);
              end
            end
          end
          out_count++;
        end
        if (r_valid[0] && r_ready[0]) model_xfer(1'b0, r_data0, r_last[0]);
        if (r_valid[1] && r_ready[1]) model_xfer(1'b1, r_data1, r_last[1]);
      end
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    stall0 = 1'b0;
    stall1 = 1'b0;
    @(posedge clk_2f);
    #2;
    src0_q.delete();
    src1_q.delete();
    @(negedge clk_2f);
    @(negedge clk_2f);
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_2f);
      #1;
      if (src0_q.size() == 0 && src1_q.size() == 0 && sb_q.size() == 0 && !valid_out && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk_2f);
    checks++;
    if ({valid_out, data_out, owner, busy, r_ready} !== 12'h000) begin
      errors++;
      $display("FAIL reset_values got v=%0d d=%h o=%0d b=%0d rdy=%b expected all zero",
               valid_out, data_out, owner, busy, r_ready);
    end
    @(negedge clk_2f);
    #2;
    reset = 1'b0;
    repeat (3) @(negedge clk_2f);
    checks++;
    if ({valid_out, busy, r_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_quiet got v=%0d b=%0d rdy=%b expected 0 0 00", valid_out, busy, r_ready);
    end
  endtask

  task automatic test_single_odd();
    logic [7:0] exp_d[4];
    bit ok;
    int n;
    exp_d = '{8'h11, 8'h22, 8'h33, PAD_BYTE};
    do_reset();
    src0_q.push_back({1'b0, 8'h11});
    src0_q.push_back({1'b0, 8'h22});
    src0_q.push_back({1'b1, 8'h33});
    n = 0;
    do begin @(negedge clk_2f); n++; end while (!r_valid[0] && n < 10);
    checks++;
    if (r_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL odd_ready_early got %0d expected 0", r_ready[0]);
    end
    @(negedge clk_2f);
    checks++;
    if (r_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL odd_grant_latency got %0d expected 1", r_ready[0]);
    end
    @(negedge clk_2f);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk_2f);
      checks++;
      if ({valid_out, owner, data_out} !== {1'b1, 1'b0, exp_d[i]}) begin
        errors++;
        $display("FAIL odd_stream[%0d] got v=%0d o=%0d d=%h expected v=1 o=0 d=%h",
                 i, valid_out, owner, data_out, exp_d[i]);
      end
    end
    @(negedge clk_2f);
    checks++;
    if ({valid_out, busy} !== 2'b00) begin
      errors++;
      $display("FAIL odd_final got v=%0d busy=%0d expected 0 0", valid_out, busy);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL odd_drain got timeout expected drained"); end
  endtask

  task automatic test_simultaneous();
    int n;
    logic       eo;
    logic [7:0] ed;
    int         idx;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      src0_q.push_back({1'b0, 8'(i)});
      src1_q.push_back({1'b0, 8'(8'h80 + i)});
    end
    n = 0;
    do begin @(negedge clk_2f); n++; end while (!valid_out && n < 20);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk_2f);
      eo  = ((i / 4) % 2) == 1;
      idx = (i / 8) * 4 + (i % 4);
      ed  = eo ? 8'(8'h80 + idx) : 8'(idx);
      checks++;
      if ({valid_out, owner, data_out} !== {1'b1, eo, ed}) begin
        errors++;
        $display("FAIL simul[%0d] got v=%0d o=%0d d=%h expected v=1 o=%0d d=%h",
                 i, valid_out, owner, data_out, eo, ed);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int n;
    do_reset();
    for (int i = 1; i <= 6; i++) src1_q.push_back({(i == 6), 8'(8'hA0 + i)});
    n = 0;
    do begin @(negedge clk_2f); n++; end while (!(r_valid[1] && r_ready[1]) && n < 10);
    checks++;
    if (!(r_valid[1] && r_ready[1])) begin
      errors++;
      $display("FAIL stall_grant got timeout expected req1 transfer");
    end
    stall1 = 1'b1;
    @(negedge clk_2f);
    checks++;
    if ({r_valid[1], r_ready[1], valid_out, data_out} !== {3'b011, 8'hA1}) begin
      errors++;
      $display("FAIL stall_c1 got val=%0d rdy=%0d v=%0d d=%h expected 0 1 1 a1",
               r_valid[1], r_ready[1], valid_out, data_out);
    end
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk_2f);
      checks++;
      if ({r_valid[1], r_ready[1], valid_out} !== 3'b010) begin
        errors++;
        $display("FAIL stall_c%0d got val=%0d rdy=%0d v=%0d expected 0 1 0",
                 i, r_valid[1], r_ready[1], valid_out);
      end
    end
    stall1 = 1'b0;
    @(negedge clk_2f);
    checks++;
    if ({r_valid[1], r_ready[1], valid_out} !== 3'b110) begin
      errors++;
      $display("FAIL stall_c4 got val=%0d rdy=%0d v=%0d expected 1 1 0",
               r_valid[1], r_ready[1], valid_out);
    end
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk_2f);
      checks++;
      if ({valid_out, data_out} !== {1'b1, 8'(8'hA0 + i)}) begin
        errors++;
        $display("FAIL stall_resume[%0d] got v=%0d d=%h expected v=1 d=%h",
                 i, valid_out, data_out, 8'(8'hA0 + i));
      end
    end
    @(negedge clk_2f);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL stall_cnt_kept got v=%0d d=%h expected burst end gap v=0", valid_out, data_out);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_drain got timeout expected drained"); end
  endtask

  task automatic test_pad_handoff();
    bit ok;
    int n;
    do_reset();
    src0_q.push_back({1'b1, 8'h5A});
    src1_q.push_back({1'b0, 8'hC1});
    src1_q.push_back({1'b1, 8'hC2});
    n = 0;
    do begin @(negedge clk_2f); n++; end while (!(r_valid[0] && r_ready[0]) && n < 10);
    checks++;
    if (!(r_valid[0] && r_ready[0])) begin
      errors++;
      $display("FAIL pad_grant0 got timeout expected req0 transfer");
    end
    @(negedge clk_2f);
    checks++;
    if ({r_ready, busy, valid_out, owner, data_out} !== {2'b00, 1'b1, 1'b1, 1'b0, 8'h5A}) begin
      errors++;
      $display("FAIL pad_c1 got rdy=%b b=%0d v=%0d o=%0d d=%h expected 00 1 1 0 5a",
               r_ready, busy, valid_out, owner, data_out);
    end
    @(negedge clk_2f);
    checks++;
    if ({r_ready, valid_out, owner, data_out} !== {2'b10, 1'b1, 1'b0, PAD_BYTE}) begin
      errors++;
      $display("FAIL pad_c2 got rdy=%b v=%0d o=%0d d=%h expected 10 1 0 bc",
               r_ready, valid_out, owner, data_out);
    end
    @(negedge clk_2f);
    checks++;
    if ({valid_out, owner, data_out} !== {1'b1, 1'b1, 8'hC1}) begin
      errors++;
      $display("FAIL pad_c3 got v=%0d o=%0d d=%h expected 1 1 c1", valid_out, owner, data_out);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pad_drain got timeout expected drained"); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    do_reset();
    for (int i = 1; i <= 4; i++) src1_q.push_back({1'b0, 8'(8'hB0 + i)});
    n = 0;
    do begin @(negedge clk_2f); #1; n++; end while (out_count < 2 && n < 20);
    checks++;
    if (out_count < 2) begin
      errors++;
      $display("FAIL rmid_progress got %0d outputs expected 2", out_count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({valid_out, r_ready[1], busy, data_out} !== {3'b000, 8'h00}) begin
      errors++;
      $display("FAIL rmid_async got v=%0d rdy1=%0d b=%0d d=%h expected 0 0 0 00",
               valid_out, r_ready[1], busy, data_out);
    end
    @(posedge clk_2f);
    #2;
    src0_q.delete();
    src1_q.delete();
    src0_q.push_back({1'b0, 8'hD1});
    src0_q.push_back({1'b1, 8'hD2});
    src1_q.push_back({1'b0, 8'hE1});
    src1_q.push_back({1'b1, 8'hE2});
    @(negedge clk_2f);
    @(negedge clk_2f);
    #2;
    reset = 1'b0;
    n = 0;
    do begin @(negedge clk_2f); n++; end while (r_ready == 2'b00 && n < 10);
    checks++;
    if (r_ready !== 2'b01) begin
      errors++;
      $display("FAIL rmid_first_grant got rdy=%b expected 01", r_ready);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_drain got timeout expected drained"); end
  endtask

  task automatic test_parity();
    bit ok;
    int len;
    logic [8:0] ent;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 6; p++) begin
        len = $urandom_range(1, 9);
        for (int b = 0; b < len; b++) begin
          ent = {(b == len - 1), 8'($urandom_range(0, 255))};
          if (r == 0) src0_q.push_back(ent);
          else        src1_q.push_back(ent);
        end
      end
    end
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk_2f);
      stall0 = ($urandom_range(0, 3) == 0);
      stall1 = ($urandom_range(0, 3) == 0);
      if (src0_q.size() == 0 && src1_q.size() == 0) break;
    end
    stall0 = 1'b0;
    stall1 = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL parity_drain got timeout expected drained"); end
    checks++;
    if (out_count % 2 != 0) begin
      errors++;
      $display("FAIL parity_total got %0d bytes expected even count", out_count);
    end
  endtask

  initial begin
    fork
      src0_proc();
      src1_proc();
      monitor();
    join_none
    test_reset();
    test_single_odd();
    test_simultaneous();
    test_stall();
    test_pad_handoff();
    test_reset_mid();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
